// File: rtl/collatz_pkg.sv
// ============================================================================
// collatz_pkg : shared state encoding and constants for the Collatz engine
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package collatz_pkg;

    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_TERMINAL      = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : collatz_pkg

`default_nettype wire

// File: rtl/collatz_step.sv
// ============================================================================
// collatz_step : combinational single Collatz step with overflow detection
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module collatz_step
    import collatz_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] next_x_o,
    output logic             is_terminal_o,
    output logic             step_ovf_o
);

    // 3x+1 carried at WIDTH+2 bits so the overflow shows up in the top two bits
    logic [WIDTH+1:0] w_3x1;

    assign w_3x1         = {1'b0, x_i, 1'b0} + {2'b00, x_i} + (WIDTH+2)'(1);
    assign is_terminal_o = (x_i <= WIDTH'(c_TERMINAL));
    assign step_ovf_o    = x_i[0] & (|w_3x1[WIDTH+1:WIDTH]);
    assign next_x_o      = x_i[0] ? w_3x1[WIDTH-1:0] : (x_i >> 1);

endmodule : collatz_step

`default_nettype wire

// File: rtl/collatz_main.sv
// ============================================================================
// collatz_main : iterative Collatz (3n+1) engine, one step per clock
// Optional step counter output enabled by COLLATZ_STEPS_EN
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module collatz_main
    import collatz_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic [WIDTH-1:0] co,
    output logic             bs,
    output logic [WIDTH-1:0] x,
    output logic             ovf
`ifdef COLLATZ_STEPS_EN
    ,
    output logic [WIDTH-1:0] steps
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             bs_q, bs_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] w_next_x;
    logic             w_is_terminal;
    logic             w_step_ovf;

    collatz_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .x_i           (x_q),
        .next_x_o      (w_next_x),
        .is_terminal_o (w_is_terminal),
        .step_ovf_o    (w_step_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            bs_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            bs_q    <= bs_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        bs_d    = bs_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (st) begin
                    x_d     = co;
                    ovf_d   = 1'b0;
                    bs_d    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_is_terminal) begin
                    bs_d    = 1'b0;
                    state_d = IDLE;
                end else if (w_step_ovf) begin
                    // abort with x left at the last value that fit
                    ovf_d   = 1'b1;
                    bs_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    x_d = w_next_x;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef COLLATZ_STEPS_EN
    logic [WIDTH-1:0] steps_q, steps_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    // counts only the steps actually written to x; saturates instead of wrapping
    always_comb begin
        steps_d = steps_q;
        if (state_q == IDLE) begin
            if (st) begin
                steps_d = '0;
            end
        end else if (!w_is_terminal && !w_step_ovf && (steps_q != '1)) begin
            steps_d = steps_q + WIDTH'(1);
        end
    end

    assign steps = steps_q;
`endif

    assign bs  = bs_q;
    assign x   = x_q;
    assign ovf = ovf_q;

endmodule : collatz_main

`default_nettype wire

// File: tb/tb_collatz_main.sv
// ============================================================================
// tb_collatz_main : directed self-checking bench for collatz_main
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module tb_collatz_main;

    localparam int c_W     = 16;
    localparam int c_BOUND = 1000;

    logic           clk = 1'b0;
    logic           rst;
    logic           st;
    logic [c_W-1:0] co;
    logic           bs;
    logic [c_W-1:0] x;
    logic           ovf;
`ifdef COLLATZ_STEPS_EN
    logic [c_W-1:0] steps;
`endif

    collatz_main #(
        .WIDTH (c_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .st    (st),
        .co    (co),
        .bs    (bs),
        .x     (x),
        .ovf   (ovf)
`ifdef COLLATZ_STEPS_EN
        ,
        .steps (steps)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int seed;
        int nsteps;
        int peak;
        int fin;
        int ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts a run with seed, counts busy cycles sampled on falling edges and
    // tracks the peak value; optionally re-pulses st with seed 8 mid-run.
    task automatic run_seq(input int seed, input int inject_at,
                           output int cycles, output int peak);
        @(negedge clk);
        co = c_W'(seed);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        cycles = 0;
        peak   = 0;
        while (bs && cycles < c_BOUND) begin
            cycles++;
            if (int'(x) > peak) peak = int'(x);
            if (cycles == inject_at) begin
                co = c_W'(8);
                st = 1'b1;
            end else begin
                st = 1'b0;
                co = c_W'(seed ^ 16'h5a5a);
            end
            @(negedge clk);
        end
        st = 1'b0;
        if (cycles >= c_BOUND) begin
            check("run_timeout", cycles, -1);
        end
    endtask

    int cyc, pk;

    initial begin
        vecs[0]  = '{8,     3,   8,     1,     0};
        vecs[1]  = '{7,     16,  52,    1,     0};
        vecs[2]  = '{65535, 0,   65535, 65535, 1};
        vecs[3]  = '{27,    111, 9232,  1,     0};
        vecs[4]  = '{0,     0,   0,     0,     0};
        vecs[5]  = '{1,     0,   1,     1,     0};
        vecs[6]  = '{21845, 0,   21845, 21845, 1};
        vecs[7]  = '{2,     1,   2,     1,     0};
        vecs[8]  = '{21843, 2,   65530, 32765, 1};
        vecs[9]  = '{32768, 15,  32768, 1,     0};
        vecs[10] = '{3,     7,   16,    1,     0};

        rst = 1'b1;
        st  = 1'b0;
        co  = '0;
        repeat (2) @(negedge clk);
        check("reset_x",   int'(x),   0);
        check("reset_bs",  int'(bs),  0);
        check("reset_ovf", int'(ovf), 0);
`ifdef COLLATZ_STEPS_EN
        check("reset_steps", int'(steps), 0);
`endif
        rst = 1'b0;

        // explicit trajectory for seed 8: 8,4,2,1 then busy drops
        @(negedge clk);
        co = 16'd8;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        check("seq8_x0", int'(x), 8);
        check("seq8_bs0", int'(bs), 1);
        @(negedge clk); check("seq8_x1", int'(x), 4);
        @(negedge clk); check("seq8_x2", int'(x), 2);
        @(negedge clk); check("seq8_x3", int'(x), 1);
        check("seq8_bs3", int'(bs), 1);
        @(negedge clk); check("seq8_bs4", int'(bs), 0);
        check("seq8_xhold", int'(x), 1);

        for (int i = 0; i < 11; i++) begin
            run_seq(vecs[i].seed, -1, cyc, pk);
            check($sformatf("v%0d_busy_cycles", vecs[i].seed), cyc, vecs[i].nsteps + 1);
            check($sformatf("v%0d_peak", vecs[i].seed), pk, vecs[i].peak);
            check($sformatf("v%0d_final_x", vecs[i].seed), int'(x), vecs[i].fin);
            check($sformatf("v%0d_ovf", vecs[i].seed), int'(ovf), vecs[i].ovf);
`ifdef COLLATZ_STEPS_EN
            check($sformatf("v%0d_steps", vecs[i].seed), int'(steps), vecs[i].nsteps);
`endif
            // idle with st low must hold every output
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_idle_hold_x", vecs[i].seed), int'(x), vecs[i].fin);
            check($sformatf("v%0d_idle_hold_ovf", vecs[i].seed), int'(ovf), vecs[i].ovf);
        end

        // restart attempt while busy is ignored
        run_seq(27, 5, cyc, pk);
        check("restart_busy_cycles", cyc, 112);
        check("restart_peak", pk, 9232);
        check("restart_final_x", int'(x), 1);
        check("restart_ovf", int'(ovf), 0);
`ifdef COLLATZ_STEPS_EN
        check("restart_steps", int'(steps), 111);
`endif

        // asynchronous reset mid-run
        @(negedge clk);
        co = 16'd27;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_busy_before", int'(bs), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_x", int'(x), 0);
        check("midrst_bs", int'(bs), 0);
        check("midrst_ovf", int'(ovf), 0);
`ifdef COLLATZ_STEPS_EN
        check("midrst_steps", int'(steps), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("postrst_bs", int'(bs), 0);
        check("postrst_x", int'(x), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_collatz_main

`default_nettype wire
